// File: rtl/bsg_nand_two_fifo_if.sv
// Handshake bundle for bsg_nand_two_fifo: operand input, result output, delivered-word counter.
// Optional BSG_NAND_TWO_FIFO_PARITY_EN adds parity_o.
interface bsg_nand_two_fifo_if #(
  parameter int unsigned width_p     = 16,
  parameter int unsigned cnt_width_p = 16
);
  logic                   v_i;
  logic [width_p-1:0]     a_i;
  logic [width_p-1:0]     b_i;
  logic                   ready_o;
  logic                   v_o;
  logic [width_p-1:0]     data_o;
  logic                   yumi_i;
  logic [cnt_width_p-1:0] xfer_cnt_o;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
  logic                   parity_o;
`endif

  modport master (
    output v_i, a_i, b_i, yumi_i,
    input  ready_o, v_o, data_o, xfer_cnt_o
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
    , input parity_o
`endif
  );

  modport slave (
    input  v_i, a_i, b_i, yumi_i,
    output ready_o, v_o, data_o, xfer_cnt_o
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
    , output parity_o
`endif
  );
endinterface

// File: rtl/bsg_nand_two_fifo.sv
// Two-entry elastic buffer storing ~(a_i & b_i), with a delivered-word counter.
// Define BSG_NAND_TWO_FIFO_PARITY_EN to store and present an even-parity bit per entry.
module bsg_nand_two_fifo #(
  parameter int unsigned width_p     = 16,
  parameter int unsigned cnt_width_p = 16
) (
  input logic               clk_i,
  input logic               reset_n_i,
  bsg_nand_two_fifo_if.slave io
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                 state_q, state_d;
  logic [width_p-1:0]     entry_q [2];
  logic [width_p-1:0]     entry_d [2];
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;
  logic [width_p-1:0]     nand_w;
  logic                   ready, valid, enq, deq;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
  logic                   par_q [2];
  logic                   par_d [2];
`endif

  assign nand_w = ~(io.a_i & io.b_i);

  // Outputs depend only on registers (and reset, which forces ready low).
  always_comb begin
    ready = reset_n_i && (state_q != StFull);
    valid = (state_q != StEmpty);
    enq   = io.v_i && ready;
    deq   = io.yumi_i && valid;
  end

  assign io.ready_o    = ready;
  assign io.v_o        = valid;
  assign io.data_o     = entry_q[rptr_q];
  assign io.xfer_cnt_o = cnt_q;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
  assign io.parity_o   = par_q[rptr_q];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (enq) state_d = StOne;
      StOne: begin
        if (enq && !deq)      state_d = StFull;
        else if (deq && !enq) state_d = StEmpty;
      end
      StFull:  if (deq) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    entry_d = entry_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
    par_d   = par_q;
`endif
    if (enq) begin
      entry_d[wptr_q] = nand_w;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
      par_d[wptr_q]   = ^nand_w;
`endif
      wptr_d          = ~wptr_q;
    end
    if (deq) begin
      rptr_d = ~rptr_q;
      cnt_d  = cnt_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StEmpty;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
      par_q[0]   <= 1'b0;
      par_q[1]   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
`ifdef BSG_NAND_TWO_FIFO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Consuming from an empty buffer is a protocol error upstream of this block.
  yumi_without_valid_a: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) io.yumi_i |-> valid
  );

endmodule

// File: doc/bsg_nand_two_fifo.md
Name: bsg_nand_two_fifo

Overview:
- Registered, flow-controlled consumer stage directly downstream of the combinational bitwise NAND.
- Computes ~(a_i & b_i) per bit on accepted input and stores the result in a 2-entry elastic buffer.
- Presents stored results to the next stage with valid/yumi, decoupling the NAND's combinational path from downstream timing.
- Keeps a running count of delivered words for debug and perf monitoring.

Parameters:
- width_p, 16, data width of a_i, b_i, data_o
- cnt_width_p, 16, width of the delivered-word counter xfer_cnt_o

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge
- reset_n_i  in  1  asynchronous active-low reset; asserts immediately, deassertion synchronised externally
- v_i  in  1  input word valid
- a_i  in  width_p  operand A
- b_i  in  width_p  operand B
- ready_o  out  1  stage can accept; transfer occurs when v_i & ready_o
- v_o  out  1  data_o holds a valid result
- data_o  out  width_p  head entry = stored ~(a_i & b_i)
- yumi_i  in  1  downstream consumes head this cycle; legal only when v_o=1
- xfer_cnt_o  out  cnt_width_p  number of words dequeued since reset

Behaviour:
- Reset (reset_n_i=0, async): state EMPTY, both storage entries 0, read/write pointers 0, v_o=0, data_o=0, xfer_cnt_o=0, ready_o forced 0 while reset_n_i=0.
- Storage: 2 entries, 1-bit write pointer wptr, 1-bit read pointer rptr, both wrap 1->0.
- States: EMPTY, ONE, FULL.
  - ready_o = reset_n_i & (state != FULL).
  - v_o = (state != EMPTY).
- enq = v_i & ready_o; deq = yumi_i & v_o.
- Transitions:
  - EMPTY: enq -> ONE; else stay.
  - ONE: enq & ~deq -> FULL; deq & ~enq -> EMPTY; enq & deq -> ONE (pointers both advance); neither -> stay.
  - FULL: deq -> ONE; enq impossible since ready_o=0.
- On enq: entry[wptr] <= ~(a_i & b_i) bitwise, full width_p, no sign or width extension; wptr toggles.
- On deq: rptr toggles; xfer_cnt_o += 1, wrapping modulo 2^cnt_width_p (all-ones -> 0, no saturation).
- data_o = entry[rptr] combinationally from registers; no combinational path from a_i/b_i/v_i to any output.
- Latency: word accepted in cycle N is visible on data_o/v_o in cycle N+1 when queue was EMPTY.
- Throughput: 1 word/cycle sustained when yumi_i is held high.
- Ordering: strict FIFO.
- yumi_i while v_o=0: ignored, no state change; simulation assertion flags it as an error.
- v_i while ready_o=0: ignored; the upstream must hold data.
- Reset mid-operation: all queued data dropped, counter cleared, outputs return to reset values in the same cycle reset asserts.

Optional Feature:
- Macro BSG_NAND_TWO_FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed as ^(~(a_i & b_i)) at enq.
  - Extra output port parity_o (out, 1) presents the head entry's parity.
  - parity_o resets to 0.
- Undefined: no parity storage and no parity_o port; all other behaviour identical.

Test Plan:
- Reset then idle -> ready_o=1, v_o=0, data_o=0, xfer_cnt_o=0; assert reset_n_i=0 mid-cycle -> ready_o drops to 0 immediately.
- Single word a_i=16'hF0F0, b_i=16'hFF00, yumi_i=0 -> next cycle v_o=1, data_o=16'h0FFF; stays held until yumi_i=1, then v_o=0 and xfer_cnt_o=1.
- Fill without draining:
  - Enqueue a/b = 16'hFFFF/16'hFFFF, then 16'h0000/16'h1234.
  - Required: ready_o=0 after 2nd accept; head data_o=16'h0000.
  - After one yumi_i: data_o=16'hFFFF and ready_o=1.
- Streaming: v_i=1 and yumi_i=1 every cycle for 100 words -> state never FULL; outputs match ~(a&b) in order at 1/cycle; xfer_cnt_o=100.
- Counter wrap with cnt_width_p=4: 17 dequeues -> xfer_cnt_o=1.
- With BSG_NAND_TWO_FIFO_PARITY_EN, a_i=16'h0001, b_i=16'h0001 -> data_o=16'hFFFE, parity_o=1; a_i=b_i=16'h0000 -> data_o=16'hFFFF, parity_o=0.
